// File: rtl/generic_dsp_casc_param.sv
// generic_dsp_casc_param
// Parametrised DSP48-style multiply-accumulate slice for a FIOS Montgomery
// column. The A operand can be taken from the upstream slice (ACIN_i), and the
// P register can be fed back or taken from the upstream slice (PCIN_i). Either
// of these can also be logically shifted right by one limb, so carries ripple
// down a column through PCOUT_o -> PCIN_i without going through fabric.
module generic_dsp_casc_param #(
  parameter int WIDTH    = 17,
  parameter int ABREG    = 1,
  parameter int MREG     = 1,
  parameter int CREG     = 1,
  parameter int ACASCREG = 1
) (
  input  logic               clock_i,
  input  logic               reset_n_i,
  input  logic               CREG_en_i,
  input  logic               A_SEL_i,
  input  logic [8:0]         OPMODE_i,
  input  logic [WIDTH-1:0]   A_i,
  input  logic [WIDTH-1:0]   B_i,
  input  logic [47:0]        C_i,
  input  logic [WIDTH-1:0]   ACIN_i,
  input  logic [47:0]        PCIN_i,
  output logic [WIDTH-1:0]   ACOUT_o,
  output logic [47:0]        PCOUT_o,
  output logic [2*WIDTH-1:0] P_o
);

  localparam int PW = 2 * WIDTH;

  // Element k of each pipe is the operand after k register stages. Element 0
  // is the combinational selection, so ABREG and ACASCREG index the pipe directly.
  logic [WIDTH-1:0] a_pipe [0:ABREG];
  logic [WIDTH-1:0] b_pipe [0:ABREG];

  assign a_pipe[0] = A_SEL_i ? ACIN_i : A_i;
  assign b_pipe[0] = B_i;

  genvar gi;
  generate
    if (ABREG >= 1) begin : g_stage1
      logic [WIDTH-1:0] a1_reg;
      logic [WIDTH-1:0] acin1_reg;
      logic [WIDTH-1:0] b1_reg;
      logic             sel1_reg;

      // The first stage registers both A sources and the select, so the A mux works on registered values.
      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          a1_reg    <= '0;
          acin1_reg <= '0;
          b1_reg    <= '0;
          sel1_reg  <= 1'b0;
        end else begin
          a1_reg    <= A_i;
          acin1_reg <= ACIN_i;
          b1_reg    <= b_pipe[0];
          sel1_reg  <= A_SEL_i;
        end
      end

      assign a_pipe[1] = sel1_reg ? acin1_reg : a1_reg;
      assign b_pipe[1] = b1_reg;
    end

    for (gi = 2; gi <= ABREG; gi++) begin : g_stage_n
      logic [WIDTH-1:0] a_reg;
      logic [WIDTH-1:0] b_reg;

      // Later stages carry only the already-selected A operand.
      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
          a_reg <= '0;
          b_reg <= '0;
        end else begin
          a_reg <= a_pipe[gi-1];
          b_reg <= b_pipe[gi-1];
        end
      end

      assign a_pipe[gi] = a_reg;
      assign b_pipe[gi] = b_reg;
    end
  endgenerate

  // Unsigned limb product. It is exactly 2*WIDTH bits wide, so it cannot overflow.
  logic [PW-1:0] m_comb;
  logic [PW-1:0] m_val;

  assign m_comb = PW'(a_pipe[ABREG]) * PW'(b_pipe[ABREG]);

  generate
    if (MREG == 1) begin : g_mreg
      logic [PW-1:0] m_reg;

      // Optional register after the multiplier.
      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) m_reg <= '0;
        else            m_reg <= m_comb;
      end

      assign m_val = m_reg;
    end else begin : g_mcomb
      assign m_val = m_comb;
    end
  endgenerate

  logic [47:0] c_val;

  generate
    if (CREG == 1) begin : g_creg
      logic [47:0] c_reg;

      // C loads only on enable. The adder therefore sees the old C in the same cycle as the load.
      always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)     c_reg <= '0;
        else if (CREG_en_i) c_reg <= C_i;
      end

      assign c_val = c_reg;
    end else begin : g_ccomb
      assign c_val = C_i;
    end
  endgenerate

  logic [8:0]  opmode_reg;
  logic [47:0] p_reg;

  // OPMODE is registered once so that it lines up with the product it selects.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) opmode_reg <= '0;
    else            opmode_reg <= OPMODE_i;
  end

  logic [47:0] xy_mux;
  logic [47:0] z_mux;
  logic [47:0] w_mux;

  // Operand muxes. Any encoding that is not listed contributes zero rather than X.
  always_comb begin
    xy_mux = '0;
    z_mux  = '0;
    w_mux  = '0;
    if (opmode_reg[3:0] == 4'b0101) xy_mux = 48'(m_val);
    case (opmode_reg[6:4])
      3'b001:  z_mux = PCIN_i;
      3'b010:  z_mux = p_reg;
      3'b101:  z_mux = PCIN_i >> WIDTH;
      3'b110:  z_mux = p_reg >> WIDTH;
      default: z_mux = '0;
    endcase
    if (opmode_reg[8:7] == 2'b11) w_mux = c_val;
  end

  // The 48-bit accumulator wraps modulo 2^48. There is no saturation and no carry-out.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) p_reg <= '0;
    else            p_reg <= xy_mux + z_mux + w_mux;
  end

  // Gate on reset so that ACOUT_o reads zero during reset even when it is combinational (ACASCREG=0).
  assign ACOUT_o = reset_n_i ? a_pipe[ACASCREG] : '0;
  assign PCOUT_o = p_reg;
  assign P_o     = p_reg[PW-1:0];

endmodule

// File: tb/tb_generic_dsp_casc_param.sv
// Directed bench for generic_dsp_casc_param. It uses two default 17-bit slices
// chained through PCOUT/ACOUT, plus a WIDTH=23, ABREG=2, MREG=0 slice.
module tb_generic_dsp_casc_param;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // slice 0 (defaults)
  logic        s0_en, s0_sel;
  logic [8:0]  s0_op;
  logic [16:0] s0_a, s0_b, s0_acin;
  logic [47:0] s0_c, s0_pcin;
  logic [16:0] acout0;
  logic [47:0] pcout0;
  logic [33:0] p0;

  // slice 1 (defaults, cascaded from slice 0)
  logic        s1_en, s1_sel;
  logic [8:0]  s1_op;
  logic [16:0] s1_a, s1_b;
  logic [47:0] s1_c;
  logic [16:0] acout1;
  logic [47:0] pcout1;
  logic [33:0] p1;

  // slice 2 (WIDTH=23, ABREG=2, MREG=0, ACASCREG=2)
  logic        s2_en, s2_sel;
  logic [8:0]  s2_op;
  logic [22:0] s2_a, s2_b, s2_acin;
  logic [47:0] s2_c, s2_pcin;
  logic [22:0] acout2;
  logic [47:0] pcout2;
  logic [45:0] p2;

  generic_dsp_casc_param u_s0 (
    .clock_i(clk), .reset_n_i(rst_n), .CREG_en_i(s0_en), .A_SEL_i(s0_sel),
    .OPMODE_i(s0_op), .A_i(s0_a), .B_i(s0_b), .C_i(s0_c), .ACIN_i(s0_acin),
    .PCIN_i(s0_pcin), .ACOUT_o(acout0), .PCOUT_o(pcout0), .P_o(p0)
  );

  generic_dsp_casc_param u_s1 (
    .clock_i(clk), .reset_n_i(rst_n), .CREG_en_i(s1_en), .A_SEL_i(s1_sel),
    .OPMODE_i(s1_op), .A_i(s1_a), .B_i(s1_b), .C_i(s1_c), .ACIN_i(acout0),
    .PCIN_i(pcout0), .ACOUT_o(acout1), .PCOUT_o(pcout1), .P_o(p1)
  );

  generic_dsp_casc_param #(.WIDTH(23), .ABREG(2), .MREG(0), .CREG(1), .ACASCREG(2)) u_s2 (
    .clock_i(clk), .reset_n_i(rst_n), .CREG_en_i(s2_en), .A_SEL_i(s2_sel),
    .OPMODE_i(s2_op), .A_i(s2_a), .B_i(s2_b), .C_i(s2_c), .ACIN_i(s2_acin),
    .PCIN_i(s2_pcin), .ACOUT_o(acout2), .PCOUT_o(pcout2), .P_o(p2)
  );

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    total++;
    assert (obs === exp)
      $display("check %s: observed=%h expected=%h ok", tag, obs, exp);
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Start in reset with nonzero inputs everywhere.
    rst_n   = 1'b0;
    s0_en = 1'b1; s0_sel = 1'b0; s0_op = 9'h1FF; s0_a = 17'h1ABCD; s0_b = 17'h00777;
    s0_c = 48'h123456; s0_acin = '0; s0_pcin = '0;
    s1_en = 1'b0; s1_sel = 1'b0; s1_op = 9'h000; s1_a = '0; s1_b = '0; s1_c = '0;
    s2_en = 1'b0; s2_sel = 1'b0; s2_op = 9'h000; s2_a = 23'h5A5A5; s2_b = 23'h3; s2_c = 48'hABC;
    s2_acin = '0; s2_pcin = '0;
    #2;
    check("rst_p0", 48'(p0), 48'h0);
    check("rst_pcout0", pcout0, 48'h0);
    check("rst_acout0", 48'(acout0), 48'h0);
    check("rst_p1", 48'(p1), 48'h0);
    check("rst_acout2", 48'(acout2), 48'h0);
    tick();
    tick();
    #2 rst_n = 1'b1;
    s0_en = 1'b0; s0_op = 9'h000; s2_a = '0; s2_b = '0;
    tick();
    tick();

    // Basic MAC: product, then product + P.
    s0_a = 17'h1FFFF; s0_b = 17'h1FFFF; s0_op = 9'h000; tick();
    s0_a = 17'h00001; s0_b = 17'h00001; s0_op = 9'h005; tick();
    s0_op = 9'h025; tick();
    check("mac_p", 48'(p0), 48'h3FFFC0001);
    s0_op = 9'h000; tick();
    check("mac_acc", 48'(p0), 48'h3FFFC0002);

    // Shifted accumulate: (P >> 17) + 2*3.
    s0_a = 17'h1FFFF; s0_b = 17'h1FFFF; s0_op = 9'h000; tick();
    s0_a = 17'h00002; s0_b = 17'h00003; s0_op = 9'h005; tick();
    s0_op = 9'h065; tick();
    check("shacc_pre", 48'(p0), 48'h3FFFC0001);
    s0_op = 9'h000; tick();
    check("shacc_p", 48'(p0), 48'h20004);
    check("shacc_pcout", pcout0, 48'h20004);

    // C hold and same-cycle enable.
    s0_a = '0; s0_b = '0;
    s0_c = 48'h123; s0_en = 1'b1; s0_op = 9'h180; tick();
    s0_c = 48'hFFF; s0_en = 1'b0; tick();
    check("c_hold", 48'(p0), 48'h123);
    s0_en = 1'b1; tick();
    check("c_old", 48'(p0), 48'h123);
    s0_en = 1'b0; tick();
    check("c_new", 48'(p0), 48'hFFF);

    // Two-slice cascade through PCOUT -> PCIN with a limb shift.
    s0_c = 48'hA0003; s0_en = 1'b1; tick();
    s0_en = 1'b0; s1_op = 9'h055; tick();
    check("casc_pcout0", pcout0, 48'hA0003);
    tick();
    check("casc_p1", 48'(p1), 48'h5);

    // A cascade: slice1 takes slice0's ACOUT.
    s0_a = 17'h01234; s1_sel = 1'b1; s1_b = 17'h00002; s1_op = 9'h005; tick();
    check("acas_acout0", 48'(acout0), 48'h1234);
    check("acas_acout1_pre", 48'(acout1), 48'h0);
    tick();
    check("acas_acout1", 48'(acout1), 48'h1234);
    tick();
    check("acas_p1_pre", 48'(p1), 48'h0);
    tick();
    check("acas_p1", 48'(p1), 48'h2468);

    // Mid-operation reset pulse between edges.
    s0_a = 17'h00003; s0_b = 17'h00005; s0_op = 9'h005; tick();
    check("mrst_pre_pcout0", pcout0, 48'hA0003);
    check("mrst_pre_acout0", 48'(acout0), 48'h3);
    #1 rst_n = 1'b0;
    #1;
    check("mrst_p0", 48'(p0), 48'h0);
    check("mrst_pcout0", pcout0, 48'h0);
    check("mrst_acout0", 48'(acout0), 48'h0);
    #1 rst_n = 1'b1;
    tick();
    check("mrst_e1", 48'(p0), 48'h0);
    tick();
    check("mrst_e2", 48'(p0), 48'h0);
    tick();
    check("mrst_e3", 48'(p0), 48'hF);

    // Wide slice: WIDTH=23, ABREG=2, MREG=0, then an illegal OPMODE.
    s2_a = 23'h7FFFFF; s2_b = 23'h7FFFFF; s2_op = 9'h000; tick();
    s2_a = '0; s2_b = '0; s2_op = 9'h005; tick();
    check("w23_acout2", 48'(acout2), 48'h7FFFFF);
    s2_op = 9'h1FF; tick();
    check("w23_p", 48'(p2), 48'h3FFFFF000001);
    tick();
    check("w23_illegal_op", pcout2, 48'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
